// File: rtl/game_timer_ctrl.sv
// Cat-and-dog game sequencer: difficulty, BCD countdown, win/lose state, display scan select.
// Optional pause support is compiled in with TIMER_PAUSE_EN.
module game_timer_ctrl #(
    parameter int TICK_DIV = 100_000_000,
    parameter int SCAN_DIV = 50_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw6,
    input  logic       sw5,
    input  logic       btn_diff,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       win,
    output logic       count_2,
    output logic [1:0] gameDifficulty,
    output logic [1:0] gameState,
    output logic [3:0] ones,
    output logic [3:0] tens
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        ST_LOSE = 2'd0,
        ST_WIN  = 2'd1,
        ST_PLAY = 2'd2,
        ST_IDLE = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    diff_q, diff_d;
    logic [1:0]    diff_inc;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic          count_2_q, count_2_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic          run;
    logic          tick;

    function automatic logic [7:0] preset(input logic [1:0] d);
        case (d)
            2'd0:    preset = 8'h15;
            2'd1:    preset = 8'h13;
            2'd2:    preset = 8'h09;
            default: preset = 8'h07;
        endcase
    endfunction

`ifdef TIMER_PAUSE_EN
    logic paused_q, paused_d;
    assign run = (state_q == ST_PLAY) && !paused_q;
`else
    logic unused_pause;
    assign unused_pause = btn_pause;
    assign run = (state_q == ST_PLAY);
`endif

    assign tick     = run && (tick_cnt_q == TICK_LAST);
    assign diff_inc = diff_q + 2'd1;

    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        count_2_d  = count_2_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            count_2_d  = !count_2_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        diff_d     = diff_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        tick_cnt_d = tick_cnt_q;
        if (run) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (sw5 && btn_diff) begin
                    diff_d           = diff_inc;
                    {tens_d, ones_d} = preset(diff_inc);
                end else if (!sw6) begin
                    {tens_d, ones_d} = preset(diff_q);
                end else if (!sw5 && btn_start) begin
                    {tens_d, ones_d} = preset(diff_q);
                    state_d          = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (!sw6) begin
                    state_d          = ST_IDLE;
                    {tens_d, ones_d} = preset(diff_q);
                end else if (win) begin
                    state_d = ST_WIN;
                end else if (tick) begin
                    // 01 (or a stray 00) ends the game without underflow
                    if ({tens_q, ones_q} <= 8'h01) begin
                        {tens_d, ones_d} = 8'h00;
                        state_d          = ST_LOSE;
                    end else if (ones_q == 4'd0) begin
                        ones_d = 4'd9;
                        tens_d = tens_q - 4'd1;
                    end else begin
                        ones_d = ones_q - 4'd1;
                    end
                end
            end
            ST_WIN, ST_LOSE: begin
                if (!sw6 || btn_start) begin
                    state_d          = ST_IDLE;
                    {tens_d, ones_d} = preset(diff_q);
                end
            end
        endcase
        if (state_d != ST_PLAY) begin
            tick_cnt_d = '0;
        end
    end

`ifdef TIMER_PAUSE_EN
    always_comb begin
        paused_d = paused_q;
        if (state_q == ST_PLAY && btn_pause) begin
            paused_d = !paused_q;
        end
        if (state_d != ST_PLAY) begin
            paused_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            diff_q     <= 2'd0;
            tens_q     <= 4'd1;
            ones_q     <= 4'd5;
            count_2_q  <= 1'b0;
            tick_cnt_q <= '0;
            scan_cnt_q <= '0;
`ifdef TIMER_PAUSE_EN
            paused_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            diff_q     <= diff_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            count_2_q  <= count_2_d;
            tick_cnt_q <= tick_cnt_d;
            scan_cnt_q <= scan_cnt_d;
`ifdef TIMER_PAUSE_EN
            paused_q   <= paused_d;
`endif
        end
    end

    assign count_2        = count_2_q;
    assign gameDifficulty = diff_q;
    assign gameState      = state_q;
    assign tens           = tens_q;
    assign ones           = ones_q;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Bench for game_timer_ctrl: vector table for IDLE/difficulty, scripted play sequences.
module tb_game_timer_ctrl;

    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 2;
    localparam int S_LOSE = 0;
    localparam int S_WIN  = 1;
    localparam int S_PLAY = 2;
    localparam int S_IDLE = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sw6 = 1'b0;
    logic       sw5 = 1'b0;
    logic       btn_diff = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_pause = 1'b0;
    logic       win = 1'b0;
    logic       count_2;
    logic [1:0] gameDifficulty;
    logic [1:0] gameState;
    logic [3:0] ones;
    logic [3:0] tens;

    game_timer_ctrl #(
        .TICK_DIV(TICK_DIV),
        .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sw6           (sw6),
        .sw5           (sw5),
        .btn_diff      (btn_diff),
        .btn_start     (btn_start),
        .btn_pause     (btn_pause),
        .win           (win),
        .count_2       (count_2),
        .gameDifficulty(gameDifficulty),
        .gameState     (gameState),
        .ones          (ones),
        .tens          (tens)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic [1:0] df;
        logic [3:0] t;
        logic [3:0] o;
        logic       c2;
    } exp_t;

    typedef struct {
        int rst;
        int sw6;
        int sw5;
        int bd;
        int bs;
        int st;
        int df;
        int sec;
    } vec_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   sec = 15;
    int   ph = 0;
    int   df = 0;
    bit   paused = 1'b0;
    vec_t vecs[13];

    function automatic int preset_sec(input int d);
        case (d)
            0: return 15;
            1: return 13;
            2: return 9;
            default: return 7;
        endcase
    endfunction

    task automatic step(input string tag, input int r, input int bd,
                        input int bs, input int bp, input int w,
                        input int est, input int edf, input int esec);
        exp_t e;
        exp_t got;
        exp_t want;
        rst       = (r != 0);
        btn_diff  = (bd != 0);
        btn_start = (bs != 0);
        btn_pause = (bp != 0);
        win       = (w != 0);
        if (r != 0) cyc = 0;
        else cyc++;
        e.st = 2'(est);
        e.df = 2'(edf);
        e.t  = 4'(esec / 10);
        e.o  = 4'(esec % 10);
        e.c2 = ((cyc / 2) % 2) != 0;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got  = {gameState, gameDifficulty, tens, ones, count_2};
        want = sb_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got st=%0d df=%0d digits=%0h%0h c2=%0b, want st=%0d df=%0d digits=%0h%0h c2=%0b",
                     tag, got.st, got.df, got.t, got.o, got.c2,
                     want.st, want.df, want.t, want.o, want.c2);
        end
        rst       = 1'b0;
        btn_diff  = 1'b0;
        btn_start = 1'b0;
        btn_pause = 1'b0;
        win       = 1'b0;
    endtask

    task automatic start_game(input string tag);
        sec    = preset_sec(df);
        ph     = 0;
        paused = 1'b0;
        step(tag, 0, 0, 1, 0, 0, S_PLAY, df, sec);
    endtask

    task automatic play_step(input string tag, input int bp, input int w);
        bit run;
        int st;
`ifdef TIMER_PAUSE_EN
        run = !paused;
        if (bp != 0) paused = !paused;
`else
        run = 1'b1;
`endif
        if (w != 0) begin
            st     = S_WIN;
            paused = 1'b0;
        end else begin
            if (run) begin
                if (ph == TICK_DIV - 1) begin
                    ph = 0;
                    sec--;
                end else begin
                    ph++;
                end
            end
            st = (sec == 0) ? S_LOSE : S_PLAY;
        end
        step(tag, 0, 0, 0, bp, w, st, df, sec);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] digits;
        logic [7:0] want_digits;

        vecs[0]  = '{1, 1, 0, 0, 0, S_IDLE, 0, 15};
        vecs[1]  = '{0, 1, 0, 0, 0, S_IDLE, 0, 15};
        vecs[2]  = '{0, 1, 1, 1, 0, S_IDLE, 1, 13};
        vecs[3]  = '{0, 1, 1, 1, 0, S_IDLE, 2, 9};
        vecs[4]  = '{0, 1, 1, 1, 0, S_IDLE, 3, 7};
        vecs[5]  = '{0, 1, 1, 1, 0, S_IDLE, 0, 15};
        vecs[6]  = '{0, 1, 0, 1, 0, S_IDLE, 0, 15};
        vecs[7]  = '{0, 1, 1, 0, 1, S_IDLE, 0, 15};
        vecs[8]  = '{0, 0, 0, 0, 1, S_IDLE, 0, 15};
        vecs[9]  = '{0, 1, 1, 1, 0, S_IDLE, 1, 13};
        vecs[10] = '{0, 1, 1, 1, 0, S_IDLE, 2, 9};
        vecs[11] = '{0, 1, 1, 1, 0, S_IDLE, 3, 7};
        vecs[12] = '{0, 1, 0, 0, 0, S_IDLE, 3, 7};

        for (int i = 0; i < 13; i++) begin
            sw6 = (vecs[i].sw6 != 0);
            sw5 = (vecs[i].sw5 != 0);
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].bd, vecs[i].bs,
                 0, 0, vecs[i].st, vecs[i].df, vecs[i].sec);
        end
        df = 3;

        // difficult game runs out: 7 seconds of 4 cycles
        sw6 = 1'b1;
        sw5 = 1'b0;
        start_game("start3");
        for (int i = 0; i < 28; i++) play_step("cd3", 0, 0);
        step("lose_win_ignored", 0, 0, 0, 0, 1, S_LOSE, 3, 0);
        step("lose_hold", 0, 0, 0, 0, 0, S_LOSE, 3, 0);
        step("ack3", 0, 0, 1, 0, 0, S_IDLE, 3, 7);

        // easy game: tens borrow then win
        sw5 = 1'b1;
        step("to_easy", 0, 1, 0, 0, 0, S_IDLE, 0, 15);
        df  = 0;
        sw5 = 1'b0;
        start_game("start4");
        while (sec > 9) play_step("cd4", 0, 0);
        play_step("win4", 0, 1);
        step("win_hold", 0, 0, 0, 0, 0, S_WIN, 0, 9);
        step("win_hold_diff", 0, 1, 0, 0, 0, S_WIN, 0, 9);
        step("ack4", 0, 0, 1, 0, 0, S_IDLE, 0, 15);

        // win coincident with the final tick
        sw5 = 1'b1;
        step("d1", 0, 1, 0, 0, 0, S_IDLE, 1, 13);
        step("d2", 0, 1, 0, 0, 0, S_IDLE, 2, 9);
        step("d3", 0, 1, 0, 0, 0, S_IDLE, 3, 7);
        df  = 3;
        sw5 = 1'b0;
        start_game("start5");
        while (!(sec == 1 && ph == TICK_DIV - 1)) play_step("cd5", 0, 0);
        play_step("win_last_tick", 0, 1);
        step("ack5", 0, 0, 1, 0, 0, S_IDLE, 3, 7);

        // sw6 drop mid-game, then a mid-game reset
        start_game("start5b");
        for (int i = 0; i < 6; i++) play_step("cd5b", 0, 0);
        sw6 = 1'b0;
        step("sw6_off", 0, 0, 0, 0, 0, S_IDLE, 3, 7);
        sw6 = 1'b1;
        start_game("start5c");
        for (int i = 0; i < 5; i++) play_step("cd5c", 0, 0);
        step("rst_mid", 1, 0, 1, 0, 1, S_IDLE, 0, 15);
        df = 0;

        // pause at 12
        start_game("start6");
        while (!(sec == 12 && ph == 0)) play_step("cd6", 0, 0);
        play_step("pause", 1, 0);
        for (int i = 0; i < 20; i++) play_step("paused", 0, 0);
`ifdef TIMER_PAUSE_EN
        want_digits = 8'h12;
`else
        want_digits = 8'h07;
`endif
        digits = {tens, ones};
        checks++;
        if (digits !== want_digits) begin
            errors++;
            $display("FAIL pause_span: got digits=%0h want=%0h", digits, want_digits);
        end
        play_step("resume", 1, 0);
        for (int i = 0; i < 4; i++) play_step("cd6b", 0, 0);
        sw6 = 1'b0;
        step("sw6_off6", 0, 0, 0, 0, 0, S_IDLE, 0, 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
